// File: rtl/svc_pkg.sv
// Shared types and constants for the service arbiter slice.
package svc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam logic [3:0] SEG_BLANK       = 4'hF;
   localparam int         DEFAULT_NUM_SVC = 4;
   localparam int         SEG_SLICE_W     = 16;

endpackage

// File: rtl/push_debouncer.sv
// Push button synchronizer, debouncer and rising-edge one-shot.
// A new level is accepted only after it has stayed unchanged for the full debounce window.
module push_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic push_raw,
   output logic pulse
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             push_sync;
   logic             sample_q;
   logic             stable_q;
   logic [CNT_W-1:0] cnt_q;

   assign push_sync = sync_q[1];

   // Any change of the synchronized level restarts the window; only an accepted 0->1 fires.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q   <= '0;
         sample_q <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         pulse    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], push_raw};
         pulse  <= 1'b0;
         if (push_sync != sample_q) begin
            sample_q <= push_sync;
            cnt_q    <= '0;
         end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (stable_q != sample_q) begin
            stable_q <= sample_q;
            pulse    <= sample_q;
         end
      end
   end

endmodule

// File: rtl/service_arbiter.sv
// Round-robin owner of the shared push button and 7-segment display among NUM_SVC services.
// Define ARB_TIMEOUT_EN to bound the wait for a service's finish and flag a sticky err on expiry.
module service_arbiter
   import svc_pkg::*;
#(
   parameter  int NUM_SVC         = DEFAULT_NUM_SVC,
   parameter  int DEBOUNCE_CYCLES = 1_000_000,
   parameter  int RELEASE_TIMEOUT = 10_000_000,
   localparam int ID_W            = (NUM_SVC > 1) ? $clog2(NUM_SVC) : 1
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [NUM_SVC-1:0]             spdt,
   input  logic                           push_raw,
   input  logic [NUM_SVC-1:0]             svc_finish,
   input  logic [NUM_SVC*SEG_SLICE_W-1:0] svc_seg,
   output logic [NUM_SVC-1:0]             grant,
   output logic [NUM_SVC-1:0]             svc_push,
   output logic [3:0]                     seg1,
   output logic [3:0]                     seg2,
   output logic [3:0]                     seg3,
   output logic [3:0]                     seg4,
   output logic [ID_W-1:0]                active_id,
   output logic                           busy,
   output logic                           err
);

   arb_state_t               state_q, state_d;
   logic [NUM_SVC-1:0]       spdt_meta_q, spdt_sync_q;
   logic [NUM_SVC-1:0]       grant_d;
   logic [ID_W-1:0]          id_d, last_ptr_q, last_ptr_d, cand;
   logic                     found;
   logic [SEG_SLICE_W-1:0]   seg_q;
   logic [SEG_SLICE_W-1:0]   seg_slices [NUM_SVC];
   logic                     push_pulse;

   function automatic int wrap_idx(input int v);
      return (v >= NUM_SVC) ? v - NUM_SVC : v;
   endfunction

   for (genvar i = 0; i < NUM_SVC; i++) begin : g_slices
      assign seg_slices[i] = svc_seg[i*SEG_SLICE_W +: SEG_SLICE_W];
   end

   push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
      .clk      (clk),
      .resetn   (resetn),
      .push_raw (push_raw),
      .pulse    (push_pulse)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(RELEASE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RELEASE_TIMEOUT - 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             err_q;

   // Counts consecutive RELEASE cycles without finish; err stays set until reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (state_q == RELEASE && !svc_finish[active_id]) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
         if (tmo_cnt_q == TMO_LAST) err_q <= 1'b1;
      end else begin
         tmo_cnt_q <= '0;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (RELEASE_TIMEOUT != 0);
   assign err = 1'b0;
`endif

   // Round-robin search starts just after the last owner so every pending switch gets a turn.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant;
      id_d       = active_id;
      last_ptr_d = last_ptr_q;
      found      = 1'b0;
      cand       = '0;
      case (state_q)
         IDLE: begin
            for (int i = 0; i < NUM_SVC; i++) begin
               cand = ID_W'(wrap_idx(int'(last_ptr_q) + 1 + i));
               if (!found && spdt_sync_q[cand]) begin
                  found       = 1'b1;
                  state_d     = GRANT;
                  grant_d     = '0;
                  grant_d[cand] = 1'b1;
                  id_d        = cand;
                  last_ptr_d  = cand;
               end
            end
         end
         GRANT: begin
            if (!spdt_sync_q[active_id]) state_d = RELEASE;
         end
         RELEASE: begin
            if (svc_finish[active_id]) begin
               state_d = IDLE;
               grant_d = '0;
            end
`ifdef ARB_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               state_d = IDLE;
               grant_d = '0;
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         grant       <= '0;
         active_id   <= '0;
         last_ptr_q  <= ID_W'(NUM_SVC - 1);
         spdt_meta_q <= '0;
         spdt_sync_q <= '0;
         seg_q       <= {4{SEG_BLANK}};
      end else begin
         spdt_meta_q <= spdt;
         spdt_sync_q <= spdt_meta_q;
         state_q     <= state_d;
         grant       <= grant_d;
         active_id   <= id_d;
         last_ptr_q  <= last_ptr_d;
         seg_q       <= (state_q == IDLE) ? {4{SEG_BLANK}} : seg_slices[active_id];
      end
   end

   assign svc_push = (push_pulse && state_q == GRANT) ? grant : '0;
   assign busy     = (state_q != IDLE);
   assign seg1     = seg_q[15:12];
   assign seg2     = seg_q[11:8];
   assign seg3     = seg_q[7:4];
   assign seg4     = seg_q[3:0];

endmodule

// File: tb/tb_service_arbiter.sv
// Self-checking bench for service_arbiter: directed scenarios plus random switch/finish traffic
// compared every cycle against a behavioural round-robin ownership model.
module tb_service_arbiter;
   import svc_pkg::*;

   localparam int N   = 4;
   localparam int DEB = 4;
   localparam int TMO = 20;

   logic              clk;
   logic              resetn;
   logic [N-1:0]      spdt;
   logic              push_raw;
   logic [N-1:0]      svc_finish;
   logic [N*16-1:0]   svc_seg;
   logic [N-1:0]      grant;
   logic [N-1:0]      svc_push;
   logic [3:0]        seg1, seg2, seg3, seg4;
   logic [1:0]        active_id;
   logic              busy;
   logic              err;

   int                checks;
   int                errors;
   int                pulses;
   logic [N-1:0]      pulse_val;

   // Reference model: owner index (-1 = none), releasing flag, last owner, release age.
   int                owner;
   int                last;
   int                rel_cnt;
   bit                releasing;
   bit                m_err;
   bit                id_known;
   int                exp_id;
   logic [15:0]       exp_seg;
   logic [N-1:0]      pipe [$];

   service_arbiter #(
      .NUM_SVC         (N),
      .DEBOUNCE_CYCLES (DEB),
      .RELEASE_TIMEOUT (TMO)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .spdt       (spdt),
      .push_raw   (push_raw),
      .svc_finish (svc_finish),
      .svc_seg    (svc_seg),
      .grant      (grant),
      .svc_push   (svc_push),
      .seg1       (seg1),
      .seg2       (seg2),
      .seg3       (seg3),
      .seg4       (seg4),
      .active_id  (active_id),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample inputs, advance the model at the edge, then compare just after it.
   task automatic applyStimulus();
      logic              r;
      logic [N-1:0]      raw, fin, seen, exp_grant, mask;
      logic [N*16-1:0]   seg;
      bit                found;
      int                k;
      r = resetn; raw = spdt; fin = svc_finish; seg = svc_seg;
      found = 0;
      @(posedge clk);
      if (!r) begin
         owner = -1; last = N - 1; rel_cnt = 0; releasing = 0; m_err = 0;
         id_known = 1; exp_id = 0; exp_seg = 16'hFFFF;
         pipe.delete(); pipe.push_back('0); pipe.push_back('0);
      end else begin
         exp_seg = (owner >= 0) ? seg[owner*16 +: 16] : 16'hFFFF;
         seen = pipe.pop_front();
         pipe.push_back(raw);
         if (owner < 0) begin
            for (int i = 0; i < N; i++) begin
               k = (last + 1 + i) % N;
               if (!found && seen[k]) begin
                  found = 1; owner = k; last = k; exp_id = k; releasing = 0; id_known = 1;
               end
            end
         end else if (!releasing) begin
            if (!seen[owner]) begin
               releasing = 1; rel_cnt = 0;
            end
         end else begin
            if (fin[owner]) begin
               owner = -1; id_known = 0;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
               rel_cnt++;
               if (rel_cnt == TMO) begin
                  owner = -1; id_known = 0; m_err = 1;
               end
            end
`endif
         end
      end
      #1;
      exp_grant = '0;
      if (owner >= 0) exp_grant[owner] = 1'b1;
      mask = (owner >= 0 && !releasing) ? exp_grant : '0;
      checkOutput("grant", grant, exp_grant);
      checkOutput("busy", busy, (owner >= 0));
      checkOutput("segs", {seg1, seg2, seg3, seg4}, exp_seg);
      checkOutput("err", err, m_err);
      if (id_known) checkOutput("active_id", active_id, exp_id);
      checkOutput("push_gate", svc_push & ~mask, 0);
      if (svc_push != '0) begin
         pulses++;
         pulse_val = svc_push;
      end
   endtask

   initial begin
      checks = 0; errors = 0; pulses = 0; pulse_val = '0;
      owner = -1; last = N - 1; rel_cnt = 0; releasing = 0; m_err = 0;
      id_known = 0; exp_id = 0; exp_seg = 16'hFFFF;
      resetn = 1'b0; spdt = '0; push_raw = 1'b0; svc_finish = '1;
      svc_seg = {$urandom, $urandom};

      // Reset values
      applyStimulus(); applyStimulus();
      checkOutput("rst_grant", grant, 4'b0000);
      checkOutput("rst_push", svc_push, 4'b0000);
      checkOutput("rst_segs", {seg1, seg2, seg3, seg4}, 16'hFFFF);
      checkOutput("rst_id", active_id, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_err", err, 0);

      // Single switch: three-clock grant latency, display one clock later
      resetn = 1'b1; spdt = 4'b1000;
      applyStimulus(); applyStimulus();
      checkOutput("s1_grant_early", grant, 4'b0000);
      applyStimulus();
      checkOutput("s1_grant", grant, 4'b1000);
      checkOutput("s1_id", active_id, 3);
      applyStimulus();
      checkOutput("s1_segs", {seg1, seg2, seg3, seg4}, svc_seg[63:48]);
      spdt = 4'b0000;
      repeat (6) applyStimulus();

      // Round robin from reset: svc1 first, then svc2 rather than svc1 again
      resetn = 1'b0; applyStimulus(); applyStimulus();
      spdt = 4'b0110; resetn = 1'b1;
      repeat (3) applyStimulus();
      checkOutput("s2_grant1", grant, 4'b0010);
      checkOutput("s2_id1", active_id, 1);
      spdt = 4'b0100;
      for (int i = 0; i < 8 && grant != 4'b0000; i++) applyStimulus();
      checkOutput("s2_released", grant, 4'b0000);
      for (int i = 0; i < 8 && grant == 4'b0000; i++) applyStimulus();
      checkOutput("s2_grant2", grant, 4'b0100);
      checkOutput("s2_id2", active_id, 2);

      // Push: long press gives one pulse to the owner, short glitch gives none
      svc_finish = 4'b1011;
      pulses = 0; pulse_val = '0;
      push_raw = 1'b1; repeat (10) applyStimulus();
      push_raw = 1'b0; repeat (12) applyStimulus();
      checkOutput("s3_one_pulse", pulses, 1);
      checkOutput("s3_pulse_target", pulse_val, 4'b0100);
      pulses = 0;
      push_raw = 1'b1; repeat (2) applyStimulus();
      push_raw = 1'b0; repeat (12) applyStimulus();
      checkOutput("s3_glitch", pulses, 0);

      // Release waits for finish with grant held
      spdt = 4'b0000;
      repeat (8) applyStimulus();
      checkOutput("s4_hold_grant", grant, 4'b0100);
      checkOutput("s4_hold_busy", busy, 1);
      svc_finish = 4'b1111;
      applyStimulus();
      checkOutput("s4_grant_clr", grant, 4'b0000);
      checkOutput("s4_busy_clr", busy, 0);
      applyStimulus();
      checkOutput("s4_segs_blank", {seg1, seg2, seg3, seg4}, 16'hFFFF);

`ifdef ARB_TIMEOUT_EN
      // Finish never arrives: forced back to IDLE with sticky err
      spdt = 4'b0001; svc_finish = 4'b1110;
      for (int i = 0; i < 8 && grant == 4'b0000; i++) applyStimulus();
      checkOutput("s5_grant", grant, 4'b0001);
      spdt = 4'b0000;
      for (int i = 0; i < 40 && busy; i++) applyStimulus();
      checkOutput("s5_idle", busy, 0);
      checkOutput("s5_err", err, 1);
      resetn = 1'b0; applyStimulus();
      checkOutput("s5_err_rst", err, 0);
      resetn = 1'b1; svc_finish = 4'b1111;
      applyStimulus();
`else
      checkOutput("s5_err_tied", err, 0);
`endif

      // Reset during GRANT aborts on the next edge
      spdt = 4'b0010;
      for (int i = 0; i < 8 && grant == 4'b0000; i++) applyStimulus();
      checkOutput("s6_grant", grant, 4'b0010);
      resetn = 1'b0; applyStimulus();
      checkOutput("s6_grant_rst", grant, 4'b0000);
      checkOutput("s6_busy_rst", busy, 0);
      checkOutput("s6_id_rst", active_id, 0);
      checkOutput("s6_segs_rst", {seg1, seg2, seg3, seg4}, 16'hFFFF);
      checkOutput("s6_push_rst", svc_push, 4'b0000);
      resetn = 1'b1; spdt = 4'b0000;
      applyStimulus();

      // Random switch, finish, display and button traffic
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            int b;
            b = $urandom_range(0, N - 1);
            spdt[b] = ~spdt[b];
         end
         for (int i = 0; i < N; i++) begin
            if (!spdt[i]) svc_finish[i] = 1'b1;
            else if ($urandom_range(0, 3) == 0) svc_finish[i] = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 9) == 0) svc_seg = {$urandom, $urandom};
         if ($urandom_range(0, 11) == 0) push_raw = ~push_raw;
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/service_arbiter.md
Name: service_arbiter

Overview:
- Owns the shared user I/O (debounced push button, four-digit 7-segment bus) among NUM_SVC service blocks.
- Each service is selected by its SPDT switch. The stopwatch service is one such client.
- Grants exclusive ownership to one service at a time in round-robin order.
- Routes the one-shot push pulse to the owner only and muxes the owner's digits onto the display.
- Reclaims ownership via each service's finish handshake.

Parameters:
- NUM_SVC, 4, number of services; id width is clog2(NUM_SVC), min 1.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required on the synchronized push input (10 ms at 100 MHz).
- RELEASE_TIMEOUT, 10_000_000, max cycles to wait for finish in RELEASE; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  single system clock
- resetn  in  1  reset; synchronous, active-low
- spdt  in  NUM_SVC  raw service-select switches
- push_raw  in  1  raw push button
- svc_finish  in  NUM_SVC  per-service finish level (1 = service idle/released)
- svc_seg  in  NUM_SVC*16  per-service digits; slice i = svc_seg[i*16+:16] = {seg1,seg2,seg3,seg4}
- grant  out  NUM_SVC  one-hot owner, or all zero
- svc_push  out  NUM_SVC  one-cycle push pulse, gated by grant
- seg1, seg2, seg3, seg4  out  4 each  displayed digits; 4'hF = blank
- active_id  out  clog2(NUM_SVC)  owner index, valid when busy
- busy  out  1  high in GRANT and RELEASE
- err  out  1  sticky release-timeout flag

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; grant=0; svc_push=0; segs=4'hF; active_id=0; busy=0; err=0; last_ptr=NUM_SVC-1; synchronizers and debouncer cleared. Reset mid-grant aborts immediately.
- spdt and push_raw each pass through a 2-FF synchronizer before any use.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - Search spdt_sync round-robin, starting at last_ptr+1 mod NUM_SVC.
  - On the first set bit k, the next cycle enters GRANT with grant=onehot(k), active_id=k, last_ptr=k, busy=1.
  - Latency: raw switch edge to grant = 3 clk.
- GRANT:
  - Hold while spdt_sync[active_id]=1. Other switches are ignored; they stay pending.
  - When spdt_sync[active_id]=0, go to RELEASE next cycle. grant stays asserted.
- RELEASE:
  - Wait for svc_finish[active_id]=1, then go to IDLE. grant=0 and busy=0 on that transition.
  - If spdt_sync[active_id] re-rises during RELEASE, the wait for finish continues anyway. Service k may be re-granted from IDLE under normal round-robin.
  - If finish is already 1 on entry, leave after exactly 1 cycle in RELEASE.
- svc_finish is ignored in IDLE and GRANT. Services hold finish high whenever their switch is off.
- Push path:
  - Debounce counter reloads on every change of push_sync.
  - When it reaches DEBOUNCE_CYCLES with level 1 and the previous stable level was 0, emit one 1-cycle pulse.
  - svc_push = pulse & grant, in GRANT only. Pulses in IDLE/RELEASE are dropped, not queued.
  - Holding the button produces exactly one pulse.
- Display:
  - GRANT/RELEASE: segs = registered copy of svc_seg slice active_id (1-cycle latency).
  - IDLE: all 4'hF.
- At most one grant bit is ever set. grant changes only on FSM transitions.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined: a counter runs in RELEASE. After RELEASE_TIMEOUT cycles without finish, force IDLE, clear grant, and set err=1. err clears only on reset.
- Undefined: RELEASE waits indefinitely; err is tied to 0.

Decomposition:
- Shared package svc_pkg holds:
  - state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2)
  - SEG_BLANK=4'hF
  - default NUM_SVC
  - the svc_seg slice-width constant 16
- One sub-module, push_debouncer (sync + debounce + rising one-shot), parameterized by DEBOUNCE_CYCLES.

Test Plan (DEBOUNCE_CYCLES=4, RELEASE_TIMEOUT=20, NUM_SVC=4):
- Reset, then spdt=4'b1000 -> grant=4'b1000 and active_id=3 three clk after the edge; segs follow svc_seg[63:48] one cycle later.
- spdt=4'b0110 in IDLE after reset -> grant svc 1. Drop spdt[1], finish[1]=1 -> IDLE, then grant svc 2, not 1.
- In GRANT svc 2, press push_raw for 10 cycles -> exactly one svc_push=4'b0100 pulse. A 2-cycle glitch -> no pulse.
- Drop spdt[2] with finish[2]=0 for 5 cycles -> stays in RELEASE with grant held. Then finish[2]=1 -> grant=0, segs=4'hF next cycle.
- ARB_TIMEOUT_EN defined, finish never rises -> IDLE after 20 cycles, err=1. Assert resetn=0 -> err=0.
- Assert resetn=0 during GRANT -> all outputs at reset values at the next posedge.
